// File: rtl/dmem_block_copier_pkg.sv
// Shared constants for the data-memory block copier: FSM encoding and the
// memory geometry that both the copier's range check and the data memory use.
package dmem_block_copier_pkg;

  localparam int RAM_SIZE     = 256;
  localparam int RAM_SIZE_BIT = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_READ   = 3'd1;
  localparam logic [2:0] ST_WRITE  = 3'd2;
  localparam logic [2:0] ST_FINISH = 3'd3;
  localparam logic [2:0] ST_FAULT  = 3'd4;

endpackage

// File: rtl/dmem_copy_range_check.sv
// Combinational request validation and copy-direction decision for the block
// copier; all sums are widened so they cannot wrap.
module dmem_copy_range_check #(
  parameter int RAM_SIZE = 256,
  parameter int CNT_W    = 16
) (
  input  logic [31:0]      src,
  input  logic [31:0]      dst,
  input  logic [CNT_W-1:0] count,
  output logic             fault,
  output logic             backward
);

  logic [33:0] src_end_idx;
  logic [33:0] dst_end_idx;
  logic [33:0] src_end_byte;
  logic        misaligned;
  logic        out_of_range;

  assign src_end_idx  = {4'b0, src[31:2]} + {{(34-CNT_W){1'b0}}, count};
  assign dst_end_idx  = {4'b0, dst[31:2]} + {{(34-CNT_W){1'b0}}, count};
  assign src_end_byte = {2'b0, src} + {{(32-CNT_W){1'b0}}, count, 2'b00};

  assign misaligned   = (src[1:0] != 2'b00) || (dst[1:0] != 2'b00);
  assign out_of_range = (src_end_idx > 34'(RAM_SIZE)) || (dst_end_idx > 34'(RAM_SIZE));
  assign fault        = misaligned || out_of_range;

  // Destination starting inside the source block must be copied top-down.
  assign backward = (dst > src) && ({2'b0, dst} < src_end_byte);

endmodule

// File: rtl/dmem_block_copier.sv
// Data-memory bus initiator that copies a block of words with memmove
// semantics, one read cycle followed by one write cycle per word.
module dmem_block_copier #(
  parameter int RAM_SIZE = dmem_block_copier_pkg::RAM_SIZE,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [CNT_W-1:0] word_count,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [31:0]      mem_address,
  output logic [31:0]      mem_write_data,
  input  logic [31:0]      mem_read_data,
  output logic             mem_read,
  output logic             mem_write
);
  import dmem_block_copier_pkg::*;

  logic [2:0]       state;
  logic [31:0]      src_ptr;
  logic [31:0]      dst_ptr;
  logic [31:0]      buffer;
  logic [CNT_W-1:0] remaining;
  logic             dir_backward;
  logic             fault;
  logic             backward;
  logic [31:0]      last_offset;

  dmem_copy_range_check #(
    .RAM_SIZE (RAM_SIZE),
    .CNT_W    (CNT_W)
  ) u_range_check (
    .src      (src_addr),
    .dst      (dst_addr),
    .count    (word_count),
    .fault    (fault),
    .backward (backward)
  );

  // Byte offset of the last word; only used when word_count is non-zero.
  assign last_offset = {{(30-CNT_W){1'b0}}, word_count, 2'b00} - 32'd4;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      src_ptr      <= 32'd0;
      dst_ptr      <= 32'd0;
      buffer       <= 32'd0;
      remaining    <= '0;
      dir_backward <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (fault) begin
              state <= ST_FAULT;
            end else if (word_count == '0) begin
              state <= ST_FINISH;
            end else begin
              remaining    <= word_count;
              dir_backward <= backward;
              src_ptr      <= backward ? src_addr + last_offset : src_addr;
              dst_ptr      <= backward ? dst_addr + last_offset : dst_addr;
              state        <= ST_READ;
            end
          end
        end
        ST_READ: begin
          buffer <= mem_read_data;
          state  <= ST_WRITE;
        end
        ST_WRITE: begin
          src_ptr   <= dir_backward ? src_ptr - 32'd4 : src_ptr + 32'd4;
          dst_ptr   <= dir_backward ? dst_ptr - 32'd4 : dst_ptr + 32'd4;
          remaining <= remaining - 1'b1;
          state     <= (remaining == {{(CNT_W-1){1'b0}}, 1'b1}) ? ST_FINISH : ST_READ;
        end
        ST_FINISH: state <= ST_IDLE;
        ST_FAULT:  state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  assign busy           = (state == ST_READ) || (state == ST_WRITE);
  assign done           = (state == ST_FINISH);
  assign error          = (state == ST_FAULT);
  assign mem_read       = (state == ST_READ);
  assign mem_write      = (state == ST_WRITE);
  assign mem_address    = (state == ST_READ)  ? src_ptr :
                          (state == ST_WRITE) ? dst_ptr : 32'd0;
  assign mem_write_data = (state == ST_WRITE) ? buffer : 32'd0;

endmodule

// File: tb/tb_dmem_block_copier.sv
// Directed self-checking bench for dmem_block_copier with a behavioural
// data memory attached to its bus port.
module tb_dmem_block_copier;
  import dmem_block_copier_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] word_count;
  logic        busy, done, error;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_read, mem_write;

  logic [31:0] mem [0:RAM_SIZE-1];
  logic        mem_init = 1'b0;

  int tests = 0;
  int fails = 0;

  int done_cycle, error_cycle, done_pulses, error_pulses;
  int busy_count, busy_first, busy_last, n_reads, n_writes, both_seen;
  logic [31:0] wr_addrs[$];

  dmem_block_copier dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .src_addr       (src_addr),
    .dst_addr       (dst_addr),
    .word_count     (word_count),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .mem_read       (mem_read),
    .mem_write      (mem_write)
  );

  always #5 clk = ~clk;

  assign mem_read_data = mem_read ? mem[mem_address[RAM_SIZE_BIT+1:2]] : 32'd0;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < RAM_SIZE; i++) mem[i] <= (i <= 100) ? 32'(100 - i) : 32'd0;
    end else if (mem_write) begin
      mem[mem_address[RAM_SIZE_BIT+1:2]] <= mem_write_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic init_mem();
    @(negedge clk);
    mem_init = 1'b1;
    @(negedge clk);
    mem_init = 1'b0;
  endtask

  // Issues one request and watches the bus until two cycles past done/error.
  // intr_cycle > 0 fires a second, conflicting start in that cycle.
  task automatic run_copy(input logic [31:0] s, input logic [31:0] d,
                          input logic [15:0] n, input int intr_cycle);
    done_cycle = -1; error_cycle = -1; done_pulses = 0; error_pulses = 0;
    busy_count = 0; busy_first = -1; busy_last = -1;
    n_reads = 0; n_writes = 0; both_seen = 0;
    wr_addrs.delete();
    @(negedge clk);
    src_addr = s; dst_addr = d; word_count = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 64; cyc++) begin
      if (cyc == intr_cycle) begin
        start = 1'b1; src_addr = 32'h0; dst_addr = 32'h300; word_count = 16'd1;
      end else begin
        start = 1'b0;
      end
      if (busy) begin
        busy_count++;
        if (busy_first < 0) busy_first = cyc;
        busy_last = cyc;
      end
      if (done) begin
        done_pulses++;
        if (done_cycle < 0) done_cycle = cyc;
      end
      if (error) begin
        error_pulses++;
        if (error_cycle < 0) error_cycle = cyc;
      end
      if (mem_read) n_reads++;
      if (mem_write) begin
        n_writes++;
        wr_addrs.push_back(mem_address);
      end
      if (mem_read && mem_write) both_seen++;
      if (done_cycle > 0 && cyc >= done_cycle + 2) break;
      if (error_cycle > 0 && cyc >= error_cycle + 2) break;
      @(negedge clk);
    end
    start = 1'b0;
    $display("[TB] copy src=0x%0h dst=0x%0h n=%0d done@%0d error@%0d reads=%0d writes=%0d",
             s, d, n, done_cycle, error_cycle, n_reads, n_writes);
  endtask

  initial begin
    int done_seen;
    reset = 1'b1; start = 1'b0;
    src_addr = 32'd0; dst_addr = 32'd0; word_count = 16'd0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mem_address", mem_address, 32'd0);
    check("rst_mem_wdata", mem_write_data, 32'd0);
    reset = 1'b0;
    init_mem();

    // Forward, non-overlapping
    run_copy(32'h004, 32'h200, 16'd4, 0);
    check("fwd_done_cycle", 32'(done_cycle), 32'd9);
    check("fwd_done_pulses", 32'(done_pulses), 32'd1);
    check("fwd_busy_count", 32'(busy_count), 32'd8);
    check("fwd_busy_first", 32'(busy_first), 32'd1);
    check("fwd_busy_last", 32'(busy_last), 32'd8);
    check("fwd_writes", 32'(n_writes), 32'd4);
    check("fwd_both", 32'(both_seen), 32'd0);
    check("fwd_w128", mem[128], 32'd99);
    check("fwd_w129", mem[129], 32'd98);
    check("fwd_w130", mem[130], 32'd97);
    check("fwd_w131", mem[131], 32'd96);
    check("fwd_w132", mem[132], 32'd0);
    check("fwd_src1", mem[1], 32'd99);
    check("fwd_src4", mem[4], 32'd96);

    // Overlap, destination above source: must run backward
    init_mem();
    run_copy(32'h004, 32'h008, 16'd3, 0);
    check("bwd_done_cycle", 32'(done_cycle), 32'd7);
    check("bwd_writes", 32'(n_writes), 32'd3);
    check("bwd_wr0", wr_addrs[0], 32'h010);
    check("bwd_wr1", wr_addrs[1], 32'h00C);
    check("bwd_wr2", wr_addrs[2], 32'h008);
    check("bwd_w1", mem[1], 32'd99);
    check("bwd_w2", mem[2], 32'd99);
    check("bwd_w3", mem[3], 32'd98);
    check("bwd_w4", mem[4], 32'd97);
    check("bwd_w5", mem[5], 32'd95);

    // Overlap, destination below source: forward
    init_mem();
    run_copy(32'h008, 32'h004, 16'd3, 0);
    check("ovf_done_cycle", 32'(done_cycle), 32'd7);
    check("ovf_wr0", wr_addrs[0], 32'h004);
    check("ovf_wr1", wr_addrs[1], 32'h008);
    check("ovf_wr2", wr_addrs[2], 32'h00C);
    check("ovf_w1", mem[1], 32'd98);
    check("ovf_w2", mem[2], 32'd97);
    check("ovf_w3", mem[3], 32'd96);
    check("ovf_w4", mem[4], 32'd96);

    // Misaligned source
    run_copy(32'h006, 32'h100, 16'd1, 0);
    check("mis_error_cycle", 32'(error_cycle), 32'd1);
    check("mis_error_pulses", 32'(error_pulses), 32'd1);
    check("mis_done_pulses", 32'(done_pulses), 32'd0);
    check("mis_reads", 32'(n_reads), 32'd0);
    check("mis_writes", 32'(n_writes), 32'd0);
    check("mis_busy", 32'(busy_count), 32'd0);

    // Destination end just past the memory
    run_copy(32'h000, 32'h3FC, 16'd2, 0);
    check("oor_error_cycle", 32'(error_cycle), 32'd1);
    check("oor_done_pulses", 32'(done_pulses), 32'd0);
    check("oor_access", 32'(n_reads + n_writes), 32'd0);

    // Destination end exactly at the memory limit is accepted
    run_copy(32'h000, 32'h3FC, 16'd1, 0);
    check("edge_done_cycle", 32'(done_cycle), 32'd3);
    check("edge_error_pulses", 32'(error_pulses), 32'd0);
    check("edge_w255", mem[255], 32'd100);

    // Zero-length copy
    run_copy(32'h004, 32'h200, 16'd0, 0);
    check("zero_done_cycle", 32'(done_cycle), 32'd1);
    check("zero_done_pulses", 32'(done_pulses), 32'd1);
    check("zero_access", 32'(n_reads + n_writes), 32'd0);
    check("zero_busy", 32'(busy_count), 32'd0);

    // Reset asserted during the write of the second word
    init_mem();
    @(negedge clk);
    src_addr = 32'h004; dst_addr = 32'h200; word_count = 16'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rmid_in_write", 32'(mem_write), 32'd1);
    check("rmid_write_addr", mem_address, 32'h204);
    reset = 1'b1;
    #1;
    check("rmid_busy", 32'(busy), 32'd0);
    check("rmid_mem_write", 32'(mem_write), 32'd0);
    done_seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 1) reset = 1'b0;
      if (done || error) done_seen++;
    end
    $display("[TB] reset mid-copy: done/error pulses seen=%0d", done_seen);
    check("rmid_no_done", 32'(done_seen), 32'd0);
    check("rmid_w128", mem[128], 32'd99);
    check("rmid_w129", mem[129], 32'd0);
    check("rmid_w130", mem[130], 32'd0);

    // Start while busy is dropped
    init_mem();
    run_copy(32'h004, 32'h200, 16'd4, 3);
    check("bst_done_cycle", 32'(done_cycle), 32'd9);
    check("bst_done_pulses", 32'(done_pulses), 32'd1);
    check("bst_busy_count", 32'(busy_count), 32'd8);
    check("bst_writes", 32'(n_writes), 32'd4);
    check("bst_w128", mem[128], 32'd99);
    check("bst_w131", mem[131], 32'd96);
    check("bst_w192", mem[192], 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_block_copier.md
Name: dmem_block_copier

Overview:
Bus initiator that drives the data-memory port (Address / Write_data / Read_data / MemRead / MemWrite) to copy a block of 32-bit words from one word-aligned address range to another. It is started by a one-cycle pulse and arbitrated onto the data-memory port when the CPU is stalled. It handles overlapping ranges with memmove semantics, so the result equals copying through a temporary buffer. Each word takes one read cycle followed by one write cycle.

Parameters:
RAM_SIZE, 256, number of 32-bit words in the target memory.
RAM_SIZE_BIT, 8, log2(RAM_SIZE). Word index = address[RAM_SIZE_BIT+1:2].
CNT_W, 16, width of word_count.

Ports:
clk  in  1  clock.
reset  in  1  async active-high reset.
start  in  1  one-cycle request pulse. Ignored while busy.
src_addr  in  32  byte address of first source word. Sampled on start.
dst_addr  in  32  byte address of first destination word. Sampled on start.
word_count  in  CNT_W  number of words to copy. Sampled on start.
busy  out  1  high while a copy is in progress.
done  out  1  one-cycle pulse on successful completion.
error  out  1  one-cycle pulse when a request is rejected.
mem_address  out  32  memory byte address.
mem_write_data  out  32  memory write data.
mem_read_data  in  32  memory read data, combinational from mem_address when mem_read=1.
mem_read  out  1  memory read enable.
mem_write  out  1  memory write enable; write occurs at posedge clk.

Behaviour:
- Interface: reset is asynchronous and active-high; clock is clk. All state updates on posedge clk.
- Reset values: state=IDLE; busy, done, error, mem_read, mem_write = 0; mem_address, mem_write_data, internal pointers, counter, data buffer = 0.
- Reset mid-copy: abort immediately. Words already written stay written. No done or error pulse is produced.
- States: IDLE, READ, WRITE, FINISH, FAULT.
- IDLE: outputs 0. On start=1, latch the inputs and evaluate:
  - Error check: src_addr[1:0]!=0, or dst_addr[1:0]!=0, or (src_addr>>2)+word_count > RAM_SIZE, or (dst_addr>>2)+word_count > RAM_SIZE. Compute the sums in at least 33 bits so they cannot wrap. If any holds, go to FAULT.
  - Else if word_count==0, go to FINISH.
  - Else choose direction. Backward iff dst_addr > src_addr and dst_addr < src_addr + 4*word_count; otherwise forward (including dst==src).
  - Forward: pointers start at src/dst. Backward: pointers start at src+4*(count-1) and dst+4*(count-1).
  - Then go to READ.
- READ: busy=1, mem_read=1, mem_write=0, mem_address=src pointer. At the clock edge, capture mem_read_data into the buffer, then go to WRITE.
- WRITE: busy=1, mem_read=0, mem_write=1, mem_address=dst pointer, mem_write_data=buffer. At the clock edge:
  - Step both pointers by +4 (forward) or -4 (backward).
  - Decrement the remaining count.
  - If remaining count was 1, go to FINISH; else go to READ.
- FINISH: done=1, busy=0 for one cycle, then IDLE.
- FAULT: error=1, busy=0 for one cycle, then IDLE. No memory access is made for a rejected request.
- Latency: start sampled at edge 0. busy is high for cycles 1..2N. done is high in cycle 2N+1. For N=0, done is high in cycle 1.
- mem_read and mem_write are never both 1. Outside READ/WRITE: mem_address=0, mem_write_data=0.
- start during busy, FINISH or FAULT is dropped, not queued.
- Outputs are registered or decoded from state only. No combinational path from start to the mem_* outputs.

Decomposition:
- Shared package holds:
  - the state encoding constants (IDLE=0, READ=1, WRITE=2, FINISH=3, FAULT=4);
  - RAM_SIZE and RAM_SIZE_BIT, shared with the data memory so the range check and the memory's word decode cannot diverge.
- One natural sub-module, dmem_copy_range_check: combinational. Inputs src, dst, count. Outputs fault and backward. Keeps the overflow-safe arithmetic isolated and unit-testable.
- The FSM, pointers and buffer stay in the top module.

Test Plan:
- Forward copy: memory freshly reset (word0=100, word i=100-i for i=1..100, rest 0). Start with src=0x004, dst=0x200, count=4 -> words 128..131 = 99, 98, 97, 96. done in cycle 9. busy high in cycles 1..8. Source words unchanged.
- Overlap backward: src=0x004, dst=0x008, count=3 -> words 2, 3, 4 = 99, 98, 97 (memmove result). Write order is word 4, 3, 2 (mem_address 0x010, 0x00C, 0x008). Word 1 stays 99.
- Overlap forward: src=0x008, dst=0x004, count=3 -> words 1, 2, 3 = 98, 97, 96. Write order is mem_address 0x004, 0x008, 0x00C.
- Rejects:
  - src=0x006 -> error pulse in cycle 1; mem_read and mem_write stay 0 throughout.
  - dst=0x3FC, count=2 -> error, since index 255+2 > 256.
  - count=0 -> done pulse in cycle 1 with no memory access.
- Reset and busy-start handling:
  - Assert reset during the WRITE of word 2 in a count=4 copy -> busy=0 immediately, no done pulse, only word 1 of the destination modified.
  - Issue start while busy -> ignored; the original copy completes with unchanged results.
